// File: rtl/cordic_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : cordic_pkg
//  Purpose : Shared encodings for the CORDIC scheduler. This file holds the
//            FSM state codes, the operand-mux control codes and the
//            operation mode codes.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package cordic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ITER  = 3'd2,
      ST_STORE = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   // Core operand-mux select
   localparam logic [1:0] MUX_HOLD = 2'b00;
   localparam logic [1:0] MUX_LOAD = 2'b01;
   localparam logic [1:0] MUX_ITER = 2'b10;

   // Operation modes
   localparam logic MODE_ROTATE = 1'b0;
   localparam logic MODE_VECTOR = 1'b1;

   // Requester index to one-hot request/response vector
   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage : cordic_pkg
`default_nettype wire

// File: rtl/cordic_rr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : cordic_rr_arb
//  Purpose : Combinational two-way round-robin pick. A lone requester always
//            wins. When both are asking, the round-robin pointer decides.
//  Ports   : req_valid [1:0]  in   pending requests
//            rr              in   preferred requester when both ask
//            grant     [1:0] out  one-hot grant (00 when nobody asks)
//            grant_idx       out  index of the granted requester
//  Rev     : 1.0  initial release
// ============================================================================
module cordic_rr_arb
   import cordic_pkg::*;
(
   input  logic [1:0] req_valid,
   input  logic       rr,
   output logic [1:0] grant,
   output logic       grant_idx
);

   always_comb begin
      grant_idx = (req_valid == 2'b11) ? rr : req_valid[1];
      grant     = (req_valid == 2'b00) ? 2'b00 : onehot2(grant_idx);
   end

endmodule : cordic_rr_arb
`default_nettype wire

// File: rtl/cordic_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : cordic_scheduler
//  Purpose : Arbitrates two requesters onto one iterative CORDIC core. It
//            sequences the core through load, NITER iterations and result
//            capture, then returns a one-hot completion to the granted
//            requester.
//  Ports   : clka, reset_n          clock, async active-low reset
//            req_valid/req_mode [1:0]  requests and their modes (0 rot, 1 vec)
//            req_ready [1:0]      one-hot accept (combinational, IDLE only)
//            rsp_valid/rsp_ready  one-hot completion handshake
//            core_mode            mode latched at accept
//            in_mux_ctl [1:0]     00 hold, 01 load, 10 iterate
//            iter [CW-1:0]        iteration index
//            iter_en, out_load    core register / output register enables
//            grant_id, busy       current requester, not-IDLE flag
//            state [2:0]          FSM state for debug
//  Rev     : 1.0  initial release
// ============================================================================
module cordic_scheduler
   import cordic_pkg::*;
#(
   parameter int NITER = 8,
   parameter int CW    = 4
) (
   input  logic          clka,
   input  logic          reset_n,
   input  logic [1:0]    req_valid,
   input  logic [1:0]    req_mode,
   output logic [1:0]    req_ready,
   output logic [1:0]    rsp_valid,
   input  logic [1:0]    rsp_ready,
   output logic          core_mode,
   output logic [1:0]    in_mux_ctl,
   output logic [CW-1:0] iter,
   output logic          iter_en,
   output logic          out_load,
   output logic          grant_id,
   output logic          busy,
   output logic [2:0]    state
);

   // Final index is computed in CW bits so NITER = 2^CW ends on all-ones.
   localparam logic [CW-1:0] ITER_LAST = CW'(NITER - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] iter_q, iter_d;
   logic          rr_q, rr_d;
   logic          grant_q, grant_d;
   logic          mode_q, mode_d;

   logic [1:0]    arb_grant;
   logic          arb_idx;

   cordic_rr_arb u_arb (
      .req_valid (req_valid),
      .rr        (rr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   always_ff @(posedge clka or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         iter_q  <= '0;
         rr_q    <= 1'b0;
         grant_q <= 1'b0;
         mode_q  <= MODE_ROTATE;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      iter_d     = iter_q;
      rr_d       = rr_q;
      grant_d    = grant_q;
      mode_d     = mode_q;
      req_ready  = 2'b00;
      rsp_valid  = 2'b00;
      in_mux_ctl = MUX_HOLD;
      iter_en    = 1'b0;
      out_load   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // State already reads IDLE while reset is held. The reset_n term
            // keeps the accept low so no handshake can appear during reset.
            req_ready = reset_n ? arb_grant : 2'b00;
            if (|req_valid) begin
               grant_d = arb_idx;
               mode_d  = req_mode[arb_idx];
               iter_d  = '0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            in_mux_ctl = MUX_LOAD;
            iter_en    = 1'b1;
            state_d    = ST_ITER;
         end
         ST_ITER: begin
            in_mux_ctl = MUX_ITER;
            iter_en    = 1'b1;
            if (iter_q == ITER_LAST) begin
               iter_d  = '0;
               state_d = ST_STORE;
            end else begin
               iter_d  = iter_q + CW'(1);
            end
         end
         ST_STORE: begin
            out_load = 1'b1;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = onehot2(grant_q);
            if (rsp_ready[grant_q]) begin
               rr_d    = ~grant_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign iter      = iter_q;
   assign core_mode = mode_q;
   assign grant_id  = grant_q;
   assign busy      = (state_q != ST_IDLE);
   assign state     = state_q;

endmodule : cordic_scheduler
`default_nettype wire

// File: tb/tb_cordic_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_cordic_scheduler
//  Purpose : Self-checking bench for cordic_scheduler. Stimulus pushes the
//            expected grant and mode of every operation into a scoreboard.
//            A negedge monitor pops an entry at each accept. It then follows
//            the expected load/iterate/store/response timeline against the
//            DUT outputs.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_cordic_scheduler;

   localparam int NITER = 8;
   localparam int CW    = 4;

   logic          clka = 1'b0;
   logic          reset_n;
   logic [1:0]    req_valid, req_mode, req_ready, rsp_valid, rsp_ready;
   logic          core_mode, iter_en, out_load, grant_id, busy;
   logic [1:0]    in_mux_ctl;
   logic [CW-1:0] iter;
   logic [2:0]    state;

   // Second instance at the NITER = 2^CW boundary
   logic [1:0]    b_req_valid, b_req_mode, b_req_ready, b_rsp_valid, b_rsp_ready;
   logic          b_core_mode, b_iter_en, b_out_load, b_grant_id, b_busy;
   logic [1:0]    b_in_mux_ctl;
   logic [3:0]    b_iter;
   logic [2:0]    b_state;

   always #5 clka = ~clka;

   cordic_scheduler #(.NITER(NITER), .CW(CW)) dut (
      .clka(clka), .reset_n(reset_n), .req_valid(req_valid), .req_mode(req_mode),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .core_mode(core_mode), .in_mux_ctl(in_mux_ctl), .iter(iter), .iter_en(iter_en),
      .out_load(out_load), .grant_id(grant_id), .busy(busy), .state(state)
   );

   cordic_scheduler #(.NITER(16), .CW(4)) dut_b (
      .clka(clka), .reset_n(reset_n), .req_valid(b_req_valid), .req_mode(b_req_mode),
      .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .core_mode(b_core_mode), .in_mux_ctl(b_in_mux_ctl), .iter(b_iter), .iter_en(b_iter_en),
      .out_load(b_out_load), .grant_id(b_grant_id), .busy(b_busy), .state(b_state)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   function automatic logic [1:0] oh(input logic i);
      return i ? 2'b10 : 2'b01;
   endfunction

   logic [17:0] all_outs;
   assign all_outs = {req_ready, rsp_valid, core_mode, in_mux_ctl, iter,
                      iter_en, out_load, grant_id, busy, state};

   // ---------------- scoreboard + monitor ----------------
   typedef struct { logic id; logic mode; } exp_t;
   exp_t sb[$];
   exp_t e;
   int   phase = -1;   // cycles since the accept of the tracked op, -1 = none
   logic cur_id, cur_mode;

   always @(negedge clka) begin
      if (!reset_n) begin
         phase = -1;
      end else begin
         if (phase >= 0) begin
            phase++;
            if (phase == 1) begin
               chk("load_state", 32'(state), 32'd1);
               chk("load_mux", 32'(in_mux_ctl), 32'd1);
               chk("load_iter_en", 32'(iter_en), 32'd1);
               chk("load_iter", 32'(iter), 32'd0);
               chk("load_core_mode", 32'(core_mode), 32'(cur_mode));
               chk("load_grant_id", 32'(grant_id), 32'(cur_id));
            end else if (phase <= NITER + 1) begin
               chk("iter_mux", 32'(in_mux_ctl), 32'd2);
               chk("iter_index", 32'(iter), 32'(phase - 2));
               chk("iter_en", 32'(iter_en), 32'd1);
            end else if (phase == NITER + 2) begin
               chk("store_out_load", 32'(out_load), 32'd1);
               chk("store_mux", 32'(in_mux_ctl), 32'd0);
            end else begin
               chk("rsp_valid", 32'(rsp_valid), 32'(oh(cur_id)));
               if (rsp_valid[cur_id] && rsp_ready[cur_id]) phase = -1;
            end
         end
         if (|(req_valid & req_ready)) begin
            if (sb.size() == 0) begin
               chk("unexpected_accept", 32'(req_ready), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("accept_ready", 32'(req_ready), 32'(oh(e.id)));
               cur_id   = e.id;
               cur_mode = e.mode;
               phase    = 0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic push_exp(input logic id, input logic mode);
      exp_t t;
      t.id   = id;
      t.mode = mode;
      sb.push_back(t);
   endtask

   task automatic request(input logic id, input logic mode);
      bit got = 0;
      push_exp(id, mode);
      req_mode[id]  = mode;
      req_valid[id] = 1'b1;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clka);
         if (req_ready[id]) got = 1;
      end
      chk("accept_timeout", 32'(got), 32'd1);
      tick();
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp();
      bit got = 0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clka);
         if (|(rsp_valid & rsp_ready)) got = 1;
      end
      chk("rsp_timeout", 32'(got), 32'd1);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      bit got;
      reset_n = 1'b0; req_valid = 2'b00; req_mode = 2'b00; rsp_ready = 2'b00;
      b_req_valid = 2'b00; b_req_mode = 2'b00; b_rsp_ready = 2'b11;

      // Reset with random inputs: every output must stay 0
      for (int k = 0; k < 4; k++) begin
         @(posedge clka);
         #1;
         req_valid = 2'($urandom); req_mode = 2'($urandom); rsp_ready = 2'($urandom);
         #3 chk("reset_outputs", 32'(all_outs), 32'd0);
      end
      req_valid = 2'b00; req_mode = 2'b00; rsp_ready = 2'b00;
      tick();
      reset_n = 1'b1;
      tick(); tick();
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // Single request: requester 0 vectoring, response at cycle NITER+3
      rsp_ready = 2'b01;
      request(1'b0, 1'b1);
      wait_rsp();
      chk("single_back_idle", 32'(state), 32'd0);

      // Contention from reset: grant order 0, 1, 0 with back-to-back accepts
      reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
      req_mode = 2'b10; rsp_ready = 2'b11;
      push_exp(1'b0, 1'b0); push_exp(1'b1, 1'b1); push_exp(1'b0, 1'b0);
      req_valid = 2'b11;
      for (int k = 0; k < 3; k++) begin
         got = 0;
         for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clka);
            if (req_ready != 2'b00) got = 1;
         end
         chk("cont_accept_timeout", 32'(got), 32'd1);
         if (k == 0) chk("cont_first_grant", 32'(req_ready), 32'd1);
         tick();
         if (k == 2) req_valid = 2'b00;
         wait_rsp();
         if (k < 2) chk("b2b_ready", 32'(req_ready), (k == 0) ? 32'd2 : 32'd1);
      end

      // Response backpressure; requester 1 must wait until IDLE
      rsp_ready = 2'b00;
      request(1'b0, 1'b0);
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clka);
         if (rsp_valid != 2'b00) got = 1;
      end
      chk("bp_rsp_timeout", 32'(got), 32'd1);
      req_mode[1] = 1'b1; req_valid[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clka);
         chk("bp_rsp_held", 32'(rsp_valid), 32'd1);
         chk("bp_state", 32'(state), 32'd4);
         chk("bp_no_accept", 32'(req_ready), 32'd0);
      end
      push_exp(1'b1, 1'b1);
      @(posedge clka);
      #1 rsp_ready = 2'b01;
      @(negedge clka);
      tick();
      chk("bp_back_idle", 32'(state), 32'd0);
      chk("bp_next_ready", 32'(req_ready), 32'd2);
      tick();
      req_valid[1] = 1'b0;
      rsp_ready = 2'b10;
      wait_rsp();

      // Abort at iter == 3, then a fresh request completes
      rsp_ready = 2'b11;
      request(1'b0, 1'b1);
      repeat (4) @(posedge clka);
      #2 chk("abort_iter3", 32'(iter), 32'd3);
      reset_n = 1'b0;
      #1 chk("abort_outputs", 32'(all_outs), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clka);
         chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clka);
         chk("post_abort_idle", 32'({rsp_valid, busy}), 32'd0);
      end
      tick();
      request(1'b1, 1'b0);
      wait_rsp();

      // NITER = 2^CW instance: iter runs 0..15 then clears, rsp at cycle 19
      b_req_mode = 2'b00; b_req_valid = 2'b01;
      @(negedge clka);
      chk("b_accept", 32'(b_req_ready), 32'd1);
      tick();
      b_req_valid = 2'b00;
      for (int c = 1; c < 20; c++) begin
         @(negedge clka);
         if (c == 1) chk("b_load_state", 32'(b_state), 32'd1);
         else if (c <= 17) chk("b_iter", 32'({b_in_mux_ctl, b_iter}), 32'({2'b10, 4'(c - 2)}));
         else if (c == 18) chk("b_store", 32'({b_out_load, b_iter}), 32'h10);
         else chk("b_rsp", 32'(b_rsp_valid), 32'd1);
      end
      tick();
      chk("b_back_idle", 32'(b_state), 32'd0);

      repeat (2) tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("monitor_idle", 32'(phase), 32'hFFFF_FFFF);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_cordic_scheduler
`default_nettype wire
